fft_ctrl: RTL and testbench

- Memory-mapped sequencer for the FFT accelerator; sits on the CPU data bus next to the RTC and PLIC.
- On a CPU start command it:
  - reads N complex samples from the sample buffer,
  - streams them into the FFT core with contiguous in_valid,
  - captures the N outputs into the result buffer,
  - reports done, error and cycle count, with an optional interrupt.
- Replaces ad-hoc gating of the FFT clock, reset and in_valid from core signals.

---
 rtl/fft_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_fft_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_ctrl.sv
// Bus-mapped sequencer for the FFT accelerator: streams one frame of samples into
// the FFT core, captures its outputs into the result buffer and reports status.
module fft_ctrl #(
    parameter int N_POINTS   = 32,
    parameter int IN_WIDTH   = 12,
    parameter int OUT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic [3:0]            we_i,
    input  logic [3:0]            addr_i,
    input  logic [31:0]           data_i,
    output logic [31:0]           data_o,
    output logic                  irq_o,
    output logic                  smp_rd_o,
    output logic [ADDR_WIDTH-1:0] smp_addr_o,
    input  logic [31:0]           smp_data_i,
    output logic                  fft_rst_o,
    output logic                  fft_in_valid_o,
    output logic [IN_WIDTH-1:0]   fft_din_r_o,
    output logic [IN_WIDTH-1:0]   fft_din_i_o,
    input  logic                  fft_out_valid_i,
    input  logic [OUT_WIDTH-1:0]  fft_dout_r_i,
    input  logic [OUT_WIDTH-1:0]  fft_dout_i_i,
    output logic                  res_we_o,
    output logic [ADDR_WIDTH-1:0] res_addr_o,
    output logic [31:0]           res_data_o
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREFETCH = 3'd1,
        S_STREAM   = 3'd2,
        S_WAIT_OUT = 3'd3,
        S_CAPTURE  = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [31:0]           cycles_q, cycles_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  irq_en_q, irq_en_d;
    logic                  irq_q;
    logic [31:0]           data_q;
    logic [31:0]           rdata;

    logic ctrl_wr, bus_rd, start, clr;
    assign ctrl_wr = en_i && (we_i != 4'b0) && (addr_i == 4'h0);
    assign bus_rd  = en_i && (we_i == 4'b0);
    assign start   = ctrl_wr && data_i[0];
    assign clr     = ctrl_wr && data_i[2];

    // Upper sample bits and unused CTRL bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{data_i[31:3], smp_data_i[31:2*IN_WIDTH]};

    assign fft_rst_o = reset || (state_q == S_PREFETCH);
    assign irq_o     = irq_q;
    assign data_o    = data_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d        = state_q;
        k_d            = k_q;
        count_d        = count_q;
        tmo_d          = tmo_q;
        cycles_d       = cycles_q;
        done_d         = done_q;
        err_d          = err_q;
        irq_en_d       = irq_en_q;
        smp_rd_o       = 1'b0;
        smp_addr_o     = '0;
        fft_in_valid_o = 1'b0;
        fft_din_r_o    = '0;
        fft_din_i_o    = '0;
        res_we_o       = 1'b0;
        res_addr_o     = '0;
        res_data_o     = '0;

        if (ctrl_wr) irq_en_d = data_i[1];
        if (clr) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (state_q != S_IDLE && cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_PREFETCH;
                    count_d  = '0;
                    cycles_d = '0;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                end
            end
            S_PREFETCH: begin
                smp_rd_o = 1'b1;
                k_d      = '0;
                tmo_d    = '0;
                state_d  = S_STREAM;
            end
            S_STREAM: begin
                fft_in_valid_o = 1'b1;
                fft_din_r_o    = smp_data_i[2*IN_WIDTH-1:IN_WIDTH];
                fft_din_i_o    = smp_data_i[IN_WIDTH-1:0];
                if (k_q != ADDR_WIDTH'(N_POINTS - 1)) begin
                    smp_rd_o   = 1'b1;
                    smp_addr_o = k_q + ADDR_WIDTH'(1);
                    k_d        = k_q + ADDR_WIDTH'(1);
                end else begin
                    state_d = S_WAIT_OUT;
                end
            end
            S_WAIT_OUT, S_CAPTURE: begin
                if (fft_out_valid_i) begin
                    res_we_o   = 1'b1;
                    res_addr_o = count_q[ADDR_WIDTH-1:0];
                    res_data_o = 32'({fft_dout_r_i, fft_dout_i_i});
                    count_d    = count_q + CNT_W'(1);
                    tmo_d      = '0;
                    state_d    = (count_q == CNT_W'(N_POINTS - 1)) ? S_DONE : S_CAPTURE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (addr_i)
            4'h0:    rdata = {30'b0, irq_en_q, 1'b0};
            4'h4:    rdata = {25'b0, state_q, irq_en_q, err_q, done_q, state_q != S_IDLE};
            4'h8:    rdata = 32'(count_q);
            4'hC:    rdata = cycles_q;
            default: rdata = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            count_q  <= '0;
            tmo_q    <= '0;
            cycles_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            count_q  <= count_d;
            tmo_q    <= tmo_d;
            cycles_q <= cycles_d;
            done_q   <= done_d;
            err_q    <= err_d;
            irq_en_q <= irq_en_d;
            irq_q    <= done_d && irq_en_d;
            data_q   <= bus_rd ? rdata : 32'h0;
        end
    end

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl: a sample-buffer model, an FFT output driver and a
// negedge monitor that scores every stream sample and result write.
module tb_fft_ctrl;

    localparam int N  = 32;
    localparam int IW = 12;
    localparam int OW = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en_i = 1'b0;
    logic [3:0]    we_i = '0;
    logic [3:0]    addr_i = '0;
    logic [31:0]   data_i = '0;
    logic [31:0]   data_o;
    logic          irq_o;
    logic          smp_rd_o;
    logic [AW-1:0] smp_addr_o;
    logic [31:0]   smp_data_i = '0;
    logic          fft_rst_o;
    logic          fft_in_valid_o;
    logic [IW-1:0] fft_din_r_o;
    logic [IW-1:0] fft_din_i_o;
    logic          fft_out_valid_i = 1'b0;
    logic [OW-1:0] fft_dout_r_i = '0;
    logic [OW-1:0] fft_dout_i_i = '0;
    logic          res_we_o;
    logic [AW-1:0] res_addr_o;
    logic [31:0]   res_data_o;

    fft_ctrl dut (
        .clk(clk), .reset(reset), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_o), .irq_o(irq_o),
        .smp_rd_o(smp_rd_o), .smp_addr_o(smp_addr_o), .smp_data_i(smp_data_i),
        .fft_rst_o(fft_rst_o), .fft_in_valid_o(fft_in_valid_o),
        .fft_din_r_o(fft_din_r_o), .fft_din_i_o(fft_din_i_o),
        .fft_out_valid_i(fft_out_valid_i), .fft_dout_r_i(fft_dout_r_i),
        .fft_dout_i_i(fft_dout_i_i), .res_we_o(res_we_o),
        .res_addr_o(res_addr_o), .res_data_o(res_data_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int j);
        logic [15:0] r, i;
        r = 16'hA000 + 16'(j);
        i = 16'h5000 + 16'(j * 7);
        return {r, i};
    endfunction

    // Sample buffer: real = i, imag = -i, one-cycle read latency.
    logic [31:0] smp_mem [N];
    initial begin
        for (int i = 0; i < N; i++) begin
            logic [11:0] re, im;
            re = 12'(i);
            im = 12'(0 - i);
            smp_mem[i] = {8'h00, re, im};
        end
    end
    always @(posedge clk) if (smp_rd_o) smp_data_i <= smp_mem[smp_addr_o];

    // Per-frame tallies, reset when the prefetch cycle is seen.
    int   iv_len = 0, iv_runs = 0, rd_cnt = 0, res_cnt = 0, gap_wr = 0;
    logic iv_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && fft_rst_o) begin
                iv_len = 0; iv_runs = 0; rd_cnt = 1; res_cnt = 0; gap_wr = 0;
                check("pf_rd", 32'(smp_rd_o), 32'd1);
                check("pf_addr", 32'(smp_addr_o), 32'd0);
            end
            if (!reset && fft_in_valid_o) begin
                logic [11:0] er, ei;
                er = 12'(iv_len);
                ei = 12'(0 - iv_len);
                if (!iv_prev) iv_runs++;
                check("din_r", 32'(fft_din_r_o), 32'(er));
                check("din_i", 32'(fft_din_i_o), 32'(ei));
                iv_len++;
                if (smp_rd_o) begin
                    check("smp_addr", 32'(smp_addr_o), 32'(rd_cnt));
                    rd_cnt++;
                end
            end
            if (res_we_o === 1'b1) begin
                check("res_addr", 32'(res_addr_o), 32'(res_cnt));
                check("res_data", res_data_o, model_word(res_cnt));
                if (!fft_out_valid_i) gap_wr++;
                res_cnt++;
            end
            iv_prev = fft_in_valid_o;
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        en_i = 1'b1; we_i = 4'hF; addr_i = a; data_i = d;
        @(negedge clk);
        en_i = 1'b0; we_i = 4'h0; data_i = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] v);
        @(negedge clk);
        en_i = 1'b1; we_i = 4'h0; addr_i = a;
        @(negedge clk);
        v = data_o;
        en_i = 1'b0;
    endtask

    task automatic wait_iv(input logic lvl);
        int t = 0;
        while (fft_in_valid_o !== lvl && t < 600) begin
            @(negedge clk);
            t++;
        end
        check("wait_iv", 32'(fft_in_valid_o), 32'(lvl));
    endtask

    task automatic poll_idle(output logic [31:0] st);
        int t = 0;
        bus_read(4'h4, st);
        while (st[0] && t < 400) begin
            bus_read(4'h4, st);
            t++;
        end
        check("idle_wait", 32'(st[0]), 32'd0);
    endtask

    // Drives out_valid just after posedge: gap idle cycles, then N outputs with an optional hole.
    task automatic drive_out(input int gap, input int split_at, input int split_len);
        repeat (gap) @(posedge clk);
        #1;
        for (int j = 0; j < N; j++) begin
            if (j == split_at) begin
                fft_out_valid_i = 1'b0;
                repeat (split_len) @(posedge clk);
                #1;
            end
            fft_out_valid_i = 1'b1;
            {fft_dout_r_i, fft_dout_i_i} = model_word(j);
            @(posedge clk);
            #1;
        end
        fft_out_valid_i = 1'b0;
        {fft_dout_r_i, fft_dout_i_i} = '0;
    endtask

    task automatic finish_frame(input int exp_res, input logic [31:0] exp_cycles,
                                input logic [31:0] exp_st);
        logic [31:0] v;
        poll_idle(v);
        check("status", v, exp_st);
        bus_read(4'h8, v);
        check("count", v, 32'(exp_res));
        bus_read(4'hC, v);
        check("cycles", v, exp_cycles);
        check("iv_len", 32'(iv_len), 32'(N));
        check("iv_runs", 32'(iv_runs), 32'd1);
        check("rd_cnt", 32'(rd_cnt), 32'(N));
        check("res_cnt", 32'(res_cnt), 32'(exp_res));
        check("gap_wr", 32'(gap_wr), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;

        // Reset held three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fft_rst", 32'(fft_rst_o), 32'd1);
        check("rst_in_valid", 32'(fft_in_valid_o), 32'd0);
        check("rst_smp_rd", 32'(smp_rd_o), 32'd0);
        check("rst_res_we", 32'(res_we_o), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_data_o", data_o, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        bus_read(4'h4, v);
        check("rst_status", v, 32'h0);
        bus_read(4'hC, v);
        check("rst_cycles", v, 32'h0);
        @(negedge clk);
        check("data_o_idle", data_o, 32'h0);
        check("fft_rst_idle", 32'(fft_rst_o), 32'd0);

        // Frame A: 10 idle cycles, then 32 contiguous outputs.
        bus_write(4'h0, 32'h3);
        wait_iv(1'b1);
        wait_iv(1'b0);
        drive_out(10, N, 0);
        finish_frame(N, 32'd76, 32'h0A);
        check("irq_a", 32'(irq_o), 32'd1);

        // Frame B: 16 valid / 3 idle / 16 valid, with a stray start mid-stream.
        bus_write(4'h0, 32'h3);
        wait_iv(1'b1);
        repeat (3) @(negedge clk);
        bus_write(4'h0, 32'h3);
        wait_iv(1'b0);
        drive_out(10, 16, 3);
        finish_frame(N, 32'd79, 32'h0A);
        check("irq_b", 32'(irq_o), 32'd1);
        bus_write(4'h0, 32'h4);
        check("irq_clr", 32'(irq_o), 32'd0);
        bus_read(4'h4, v);
        check("status_clr", v, 32'h0);

        // Timeout: out_valid never arrives.
        bus_write(4'h0, 32'h1);
        wait_iv(1'b1);
        wait_iv(1'b0);
        finish_frame(0, 32'd289, 32'h06);
        check("irq_tmo", 32'(irq_o), 32'd0);

        // Reset during stream at k=7, then a fresh frame.
        bus_write(4'h0, 32'h1);
        wait_iv(1'b1);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_in_valid", 32'(fft_in_valid_o), 32'd0);
        check("mid_smp_rd", 32'(smp_rd_o), 32'd0);
        check("mid_fft_rst", 32'(fft_rst_o), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        bus_read(4'h4, v);
        check("mid_status", v, 32'h0);
        bus_write(4'h0, 32'h1);
        wait_iv(1'b1);
        wait_iv(1'b0);
        drive_out(2, N, 0);
        finish_frame(N, 32'd68, 32'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
